// File: rtl/mem_router_pkg.sv
// ============================================================================
// Module : mem_router_pkg
// Brief  : Shared types, limits and SoC address windows for the memory router.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } router_state_t;

  localparam int NSLAVE_MAX = 8;

  // SoC slave windows (top addresses are exclusive)
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
  localparam logic [31:0] PRINT_BASE = 32'h1000_0000;
  localparam logic [31:0] PRINT_TOP  = 32'h1000_1000;
  localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] BRAM_TOP   = 32'h8010_0000;
  localparam logic [31:0] TOHOST_ADDR = 32'h0000_1000;

  // Width of a slave index; never zero so a single-slave build still has a select bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_router_decode.sv
// ============================================================================
// Module : mem_router_decode
// Brief  : Combinational address decode: windows + tohost alias -> hit/sel/base.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_router_decode
  import mem_router_pkg::*;
#(
  parameter int                 NSLAVE     = 3,
  parameter logic [NSLAVE*32-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVE*32-1:0] SLAVE_TOP  = '0,
  parameter int                 HOST_VALID = 0,
  parameter logic [31:0]        HOST_ADDR  = 32'h0,
  parameter int                 HOST_SLAVE = 0,
  parameter int                 SEL_W      = sel_width(NSLAVE)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel,
  output logic [31:0]      base
);

  logic [NSLAVE-1:0] in_win;

  for (genvar i = 0; i < NSLAVE; i++) begin : g_win
    localparam logic [31:0] WIN_BASE = SLAVE_BASE[32*i +: 32];
    localparam logic [31:0] WIN_TOP  = SLAVE_TOP[32*i +: 32];
    // An inverted or empty window (TOP <= BASE) can never satisfy both bounds.
    assign in_win[i] = (addr >= WIN_BASE) && (addr < WIN_TOP);
  end

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    base = 32'h0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (in_win[i]) begin
        hit  = 1'b1;
        sel  = SEL_W'(i);
        base = SLAVE_BASE[32*i +: 32];
      end
    end
    if (!hit && (HOST_VALID != 0) && (addr == HOST_ADDR)) begin
      hit  = 1'b1;
      sel  = SEL_W'(HOST_SLAVE);
      base = SLAVE_BASE[32*HOST_SLAVE +: 32];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_router.sv
// ============================================================================
// Module : mem_router
// Brief  : N-slave memory router with one outstanding transaction and error
//          response for unmapped accesses. Define ROUTER_TIMEOUT_EN to add a
//          BUSY watchdog that forces an error after TIMEOUT_CYCLES.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_router
  import mem_router_pkg::*;
#(
  parameter int                   NSLAVE         = 3,
  parameter logic [NSLAVE*32-1:0] SLAVE_BASE     = '0,
  parameter logic [NSLAVE*32-1:0] SLAVE_TOP      = '0,
  parameter int                   HOST_VALID     = 0,
  parameter logic [31:0]          HOST_ADDR      = 32'h0,
  parameter int                   HOST_SLAVE     = 0,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 memory_valid,
  input  logic                 memory_instr,
  input  logic [31:0]          memory_addr,
  input  logic [31:0]          memory_wdata,
  input  logic [3:0]           memory_wstrb,
  output logic [31:0]          memory_rdata,
  output logic                 memory_ready,
  output logic                 memory_error,
  output logic [NSLAVE-1:0]    slave_valid,
  output logic                 slave_instr,
  output logic [31:0]          slave_addr,
  output logic [31:0]          slave_wdata,
  output logic [3:0]           slave_wstrb,
  input  logic [NSLAVE*32-1:0] slave_rdata,
  input  logic [NSLAVE-1:0]    slave_ready
);

  localparam int SEL_W = sel_width(NSLAVE);

  router_state_t    state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic             req_instr_q;
  logic [31:0]      req_addr_q;
  logic [31:0]      req_wdata_q;
  logic [3:0]       req_wstrb_q;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_sel;
  logic [31:0]      dec_base;
  logic [31:0]      fwd_addr;
  logic             accept;

  mem_router_decode #(
    .NSLAVE     (NSLAVE),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_TOP  (SLAVE_TOP),
    .HOST_VALID (HOST_VALID),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_SLAVE (HOST_SLAVE),
    .SEL_W      (SEL_W)
  ) u_decode (
    .addr (memory_addr),
    .hit  (dec_hit),
    .sel  (dec_sel),
    .base (dec_base)
  );

  assign fwd_addr = memory_addr - dec_base;
  assign accept   = (state_q == IDLE) && memory_valid && dec_hit;

`ifdef ROUTER_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] timer_q;
  logic        timeout;

  assign timeout = (timer_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= 32'h0;
    end else if (accept) begin
      timer_q <= 32'h0;
    end else if (state_q == BUSY) begin
      timer_q <= timer_q + 32'h1;
    end
  end
`else
  logic unused_timeout_cfg;
  logic timeout;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      req_instr_q <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q       <= dec_sel;
        req_instr_q <= memory_instr;
        req_addr_q  <= fwd_addr;
        req_wdata_q <= memory_wdata;
        req_wstrb_q <= memory_wstrb;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    slave_valid  = '0;
    slave_instr  = 1'b0;
    slave_addr   = 32'h0;
    slave_wdata  = 32'h0;
    slave_wstrb  = 4'h0;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = 32'h0;

    case (state_q)
      IDLE: begin
        slave_instr = memory_instr;
        slave_addr  = fwd_addr;
        slave_wdata = memory_wdata;
        slave_wstrb = memory_wstrb;
        if (memory_valid) begin
          if (dec_hit) begin
            slave_valid = NSLAVE'(1) << dec_sel;
            state_d     = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        slave_instr = req_instr_q;
        slave_addr  = req_addr_q;
        slave_wdata = req_wdata_q;
        slave_wstrb = req_wstrb_q;
        // A slave response in the terminal timer cycle takes priority over the timeout.
        if (slave_ready[sel_q]) begin
          memory_ready = 1'b1;
          memory_rdata = slave_rdata[32*sel_q +: 32];
          state_d      = IDLE;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      slave_valid  = '0;
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = 32'h0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_router.sv
// ============================================================================
// Module : tb_mem_router
// Brief  : Directed self-checking bench for mem_router on the SoC 3-slave map.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_router;
  import mem_router_pkg::*;

  localparam int NS = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          memory_valid;
  logic          memory_instr;
  logic [31:0]   memory_addr;
  logic [31:0]   memory_wdata;
  logic [3:0]    memory_wstrb;
  logic [31:0]   memory_rdata;
  logic          memory_ready;
  logic          memory_error;
  logic [NS-1:0] slave_valid;
  logic          slave_instr;
  logic [31:0]   slave_addr;
  logic [31:0]   slave_wdata;
  logic [3:0]    slave_wstrb;
  logic [NS*32-1:0] slave_rdata;
  logic [NS-1:0] slave_ready;

  int errors = 0;
  int checks = 0;

  mem_router #(
    .NSLAVE         (NS),
    .SLAVE_BASE     ({BRAM_BASE, PRINT_BASE, CLINT_BASE}),
    .SLAVE_TOP      ({BRAM_TOP,  PRINT_TOP,  CLINT_TOP}),
    .HOST_VALID     (1),
    .HOST_ADDR      (TOHOST_ADDR),
    .HOST_SLAVE     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .reset        (reset),
    .clock        (clock),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .memory_error (memory_error),
    .slave_valid  (slave_valid),
    .slave_instr  (slave_instr),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_wstrb  (slave_wstrb),
    .slave_rdata  (slave_rdata),
    .slave_ready  (slave_ready)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    memory_valid = 1'b1;
    memory_addr  = a;
    memory_wdata = wd;
    memory_wstrb = ws;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; memory_valid = 1'b0; memory_instr = 1'b0; memory_addr = 32'h0;
    memory_wdata = 32'h0; memory_wstrb = 4'h0; slave_rdata = '0; slave_ready = '0;
    tick; tick;
    issue(32'h8000_0010, 32'h0, 4'h0);
    checks++; if (slave_valid !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", slave_valid); end
    checks++; if (memory_ready !== 1'b0 || memory_error !== 1'b0 || memory_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got rdy=%b err=%b rdata=%h want 0/0/0", memory_ready, memory_error, memory_rdata); end
    memory_valid = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    checks++; if (memory_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready: got %b want 0", memory_ready); end
  endtask

  task automatic test_read;
    issue(32'h8000_0010, 32'h0, 4'h0);
    checks++; if (slave_valid !== 3'b100) begin errors++; $display("FAIL read_valid: got %b want 100", slave_valid); end
    checks++; if (slave_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h want 00000010", slave_addr); end
    tick;
    memory_valid = 1'b0; memory_addr = 32'h0; #1;
    checks++; if (slave_valid !== 3'b000 || memory_ready !== 1'b0 || slave_addr !== 32'h10) begin
      errors++; $display("FAIL read_busy: got v=%b rdy=%b addr=%h want 000/0/00000010", slave_valid, memory_ready, slave_addr); end
    tick;
    slave_ready = 3'b100; slave_rdata[64 +: 32] = 32'hDEAD_BEEF; #1;
    checks++; if (memory_ready !== 1'b1 || memory_rdata !== 32'hDEAD_BEEF || memory_error !== 1'b0) begin
      errors++; $display("FAIL read_resp: got rdy=%b rdata=%h err=%b want 1/deadbeef/0", memory_ready, memory_rdata, memory_error); end
    tick;
    slave_ready = '0; #1;
    checks++; if (memory_ready !== 1'b0 || memory_rdata !== 32'h0) begin
      errors++; $display("FAIL read_done: got rdy=%b rdata=%h want 0/0", memory_ready, memory_rdata); end
  endtask

  task automatic test_write;
    issue(32'h1000_0000, 32'h41, 4'hF);
    checks++; if (slave_valid !== 3'b010 || slave_addr !== 32'h0) begin
      errors++; $display("FAIL write_req: got v=%b addr=%h want 010/00000000", slave_valid, slave_addr); end
    tick;
    memory_valid = 1'b0; memory_wdata = 32'h0; memory_wstrb = 4'h0; #1;
    checks++; if (slave_wdata !== 32'h41 || slave_wstrb !== 4'hF) begin
      errors++; $display("FAIL write_hold: got wdata=%h wstrb=%h want 00000041/f", slave_wdata, slave_wstrb); end
    slave_ready = 3'b010; slave_rdata[32 +: 32] = 32'h0; #1;
    checks++; if (memory_ready !== 1'b1 || memory_error !== 1'b0) begin
      errors++; $display("FAIL write_resp: got rdy=%b err=%b want 1/0", memory_ready, memory_error); end
    tick;
    slave_ready = '0;
  endtask

  task automatic test_unmapped;
    // 0x0200C000 is the exclusive top of the clint window, so it must miss.
    logic [31:0] miss_addr [2];
    miss_addr[0] = 32'h4000_0000;
    miss_addr[1] = 32'h0200_C000;
    for (int k = 0; k < 2; k++) begin
      issue(miss_addr[k], 32'h0, 4'h0);
      checks++; if (slave_valid !== 3'b000 || memory_ready !== 1'b0) begin
        errors++; $display("FAIL unmapped_req[%0d]: got v=%b rdy=%b want 000/0", k, slave_valid, memory_ready); end
      tick;
      memory_valid = 1'b0; #1;
      checks++; if (memory_ready !== 1'b1 || memory_error !== 1'b1 || memory_rdata !== 32'h0) begin
        errors++; $display("FAIL unmapped_err[%0d]: got rdy=%b err=%b rdata=%h want 1/1/0", k, memory_ready, memory_error, memory_rdata); end
      tick;
      checks++; if (memory_ready !== 1'b0 || memory_error !== 1'b0) begin
        errors++; $display("FAIL unmapped_end[%0d]: got rdy=%b err=%b want 0/0", k, memory_ready, memory_error); end
    end
    // Last word of clint window still hits slave 0.
    issue(32'h0200_BFFC, 32'h0, 4'h0);
    checks++; if (slave_valid !== 3'b001 || slave_addr !== 32'h0000_BFFC) begin
      errors++; $display("FAIL clint_edge: got v=%b addr=%h want 001/0000bffc", slave_valid, slave_addr); end
    tick;
    memory_valid = 1'b0; slave_ready = 3'b001; slave_rdata[0 +: 32] = 32'hCAFE_0001; #1;
    checks++; if (memory_ready !== 1'b1 || memory_rdata !== 32'hCAFE_0001) begin
      errors++; $display("FAIL clint_resp: got rdy=%b rdata=%h want 1/cafe0001", memory_ready, memory_rdata); end
    tick;
    slave_ready = '0;
  endtask

  task automatic test_host_alias;
    issue(TOHOST_ADDR, 32'h1, 4'hF);
    checks++; if (slave_valid !== 3'b100 || slave_addr !== 32'h8000_1000) begin
      errors++; $display("FAIL host_alias: got v=%b addr=%h want 100/80001000", slave_valid, slave_addr); end
    tick;
    memory_valid = 1'b0; slave_ready = 3'b100; slave_rdata[64 +: 32] = 32'h0; #1;
    tick;
    slave_ready = '0;
  endtask

  task automatic test_wrong_slave;
    // A stray ready while idle must not produce a response.
    slave_ready = 3'b100; slave_rdata[64 +: 32] = 32'h9999_9999; #1;
    checks++; if (memory_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", memory_ready); end
    slave_ready = '0;
    issue(32'h8000_0000, 32'h0, 4'h0);
    tick;
    memory_valid = 1'b0; slave_ready = 3'b001; slave_rdata[0 +: 32] = 32'h1234; #1;
    checks++; if (memory_ready !== 1'b0 || memory_rdata !== 32'h0) begin
      errors++; $display("FAIL other_ready: got rdy=%b rdata=%h want 0/0", memory_ready, memory_rdata); end
    tick;
    slave_ready = 3'b100; slave_rdata[64 +: 32] = 32'h55; #1;
    checks++; if (memory_ready !== 1'b1 || memory_rdata !== 32'h55) begin
      errors++; $display("FAIL owner_ready: got rdy=%b rdata=%h want 1/00000055", memory_ready, memory_rdata); end
    tick;
    slave_ready = '0;
  endtask

  task automatic test_timeout;
    int n;
    issue(32'h1000_0004, 32'h0, 4'h0);
    tick;
    memory_valid = 1'b0; #1;
    n = 0;
    while (memory_ready !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
`ifdef ROUTER_TIMEOUT_EN
    checks++; if (n !== 16 || memory_error !== 1'b1 || memory_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout: got cycles=%0d err=%b rdata=%h want 16/1/0", n, memory_error, memory_rdata); end
    tick;
`else
    checks++; if (memory_ready !== 1'b0) begin
      errors++; $display("FAIL no_timeout: got response after %0d cycles want none", n); end
    reset = 1'b1; tick; reset = 1'b0;
`endif
  endtask

  task automatic test_reset_busy;
    int late;
    issue(32'h1000_0008, 32'h0, 4'h0);
    tick;
    memory_valid = 1'b0;
    tick;
    reset = 1'b1; slave_ready = 3'b010; slave_rdata[32 +: 32] = 32'h77; #1;
    checks++; if (memory_ready !== 1'b0 || memory_rdata !== 32'h0 || slave_valid !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got rdy=%b rdata=%h v=%b want 0/0/000", memory_ready, memory_rdata, slave_valid); end
    tick;
    reset = 1'b0; #1;
    checks++; if (memory_ready !== 1'b0) begin errors++; $display("FAIL reset_abandon: got %b want 0", memory_ready); end
    slave_ready = '0;
    late = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (memory_ready === 1'b1) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL reset_late_resp: got %0d responses want 0", late); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_unmapped;
    test_host_alias;
    test_wrong_slave;
    test_timeout;
    test_reset_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
